// File: rtl/vga_timing.sv
// vga_timing: 1344 x 806 VGA/XGA timing generator for a 65 MHz pixel clock.
// Produces registered pixel/line counters plus blanking, sync and frame-start
// flags that always agree with the counter values shown in the same cycle.
// Optional feature macro: VGA_TIMING_FRAME_CNT_EN adds an 8-bit frame_cnt output
// that counts completed frames (wraps 255 -> 0).

package vga_pkg;
    localparam int unsigned HBLANK_START = 1024;
    localparam int unsigned HBLANK_STOP  = 1344;
    localparam int unsigned HSYNC_START  = 1048;
    localparam int unsigned HSYNC_STOP   = 1184;
    localparam int unsigned VBLANK_START = 768;
    localparam int unsigned VBLANK_STOP  = 806;
    localparam int unsigned VSYNC_START  = 771;
    localparam int unsigned VSYNC_STOP   = 777;
endpackage

module vga_timing #(
    // Geometry defaults come from vga_pkg; overriding them gives a smaller raster
    parameter int unsigned HBLANK_START = vga_pkg::HBLANK_START,
    parameter int unsigned HBLANK_STOP  = vga_pkg::HBLANK_STOP,
    parameter int unsigned HSYNC_START  = vga_pkg::HSYNC_START,
    parameter int unsigned HSYNC_STOP   = vga_pkg::HSYNC_STOP,
    parameter int unsigned VBLANK_START = vga_pkg::VBLANK_START,
    parameter int unsigned VBLANK_STOP  = vga_pkg::VBLANK_STOP,
    parameter int unsigned VSYNC_START  = vga_pkg::VSYNC_START,
    parameter int unsigned VSYNC_STOP   = vga_pkg::VSYNC_STOP
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount,
    output logic        hsync,
    output logic        hblnk,
    output logic [10:0] vcount,
    output logic        vsync,
    output logic        vblnk,
    output logic        frame_start
`ifdef VGA_TIMING_FRAME_CNT_EN
    ,
    output logic [7:0]  frame_cnt
`endif
);

    localparam logic [10:0] H_LAST   = 11'(HBLANK_STOP - 1);
    localparam logic [10:0] V_LAST   = 11'(VBLANK_STOP - 1);
    localparam logic [10:0] HB_START = 11'(HBLANK_START);
    localparam logic [10:0] HB_STOP  = 11'(HBLANK_STOP);
    localparam logic [10:0] HS_START = 11'(HSYNC_START);
    localparam logic [10:0] HS_STOP  = 11'(HSYNC_STOP);
    localparam logic [10:0] VB_START = 11'(VBLANK_START);
    localparam logic [10:0] VB_STOP  = 11'(VBLANK_STOP);
    localparam logic [10:0] VS_START = 11'(VSYNC_START);
    localparam logic [10:0] VS_STOP  = 11'(VSYNC_STOP);

    logic [10:0] hcount_nxt;
    logic [10:0] vcount_nxt;
    logic        line_wrap;
    logic        hsync_nxt;
    logic        hblnk_nxt;
    logic        vsync_nxt;
    logic        vblnk_nxt;
    logic        frame_start_nxt;

    // Next counter values and the flags decoded from them, so registered flags match registered counters
    always_comb begin
        hcount_nxt = hcount;
        vcount_nxt = vcount;
        line_wrap  = (hcount == H_LAST);
        if (en) begin
            if (line_wrap) begin
                hcount_nxt = 11'd0;
                if (vcount == V_LAST) begin
                    vcount_nxt = 11'd0;
                end else begin
                    vcount_nxt = vcount + 11'd1;
                end
            end else begin
                hcount_nxt = hcount + 11'd1;
            end
        end
        hsync_nxt       = (hcount_nxt >= HS_START) && (hcount_nxt < HS_STOP);
        hblnk_nxt       = (hcount_nxt >= HB_START) && (hcount_nxt < HB_STOP);
        vsync_nxt       = (vcount_nxt >= VS_START) && (vcount_nxt < VS_STOP);
        vblnk_nxt       = (vcount_nxt >= VB_START) && (vcount_nxt < VB_STOP);
        frame_start_nxt = (hcount_nxt == 11'd0) && (vcount_nxt == 11'd0);
    end

    // Output registers; reset parks the raster at (0,0), which is a frame start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcount      <= 11'd0;
            vcount      <= 11'd0;
            hsync       <= 1'b0;
            hblnk       <= 1'b0;
            vsync       <= 1'b0;
            vblnk       <= 1'b0;
            frame_start <= 1'b1;
        end else begin
            hcount      <= hcount_nxt;
            vcount      <= vcount_nxt;
            hsync       <= hsync_nxt;
            hblnk       <= hblnk_nxt;
            vsync       <= vsync_nxt;
            vblnk       <= vblnk_nxt;
            frame_start <= frame_start_nxt;
        end
    end

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic frame_wrap;
    assign frame_wrap = en && line_wrap && (vcount == V_LAST);

    // Completed-frame counter, bumped on the en-qualified last-pixel-of-frame cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= 8'd0;
        end else if (frame_wrap) begin
            frame_cnt <= frame_cnt + 8'd1;
        end
    end
`endif

endmodule
